mram_access_arbiter: RTL

- Shares the single asynchronous parallel MRAM between two requesters: requester 0 is the host serial path and requester 1 is the on-chip test/pattern engine.
- Arbitrates round-robin and sequences one read or write per grant.
- Drives the MRAM strobes (chip_en, write_en, out_en, lower_byte_en, upper_byte_en; all active low) with programmable access and recovery timing.
- Sits between the serial/parallel converters and the MRAM pins.

---
 rtl/mram_pkg.sv | 16 +
 rtl/mram_access_arbiter_rr.sv | 24 ++
 rtl/mram_access_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mram_pkg.sv
// Shared constants for the MRAM access arbiter:
// parameter defaults, FSM encodings and strobe polarity.
package mram_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int T_ACC_DEF  = 4;
  localparam int T_REC_DEF  = 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  localparam logic STB_OFF = 1'b1;
endpackage

// File: rtl/mram_access_arbiter_rr.sv
// Two-way round-robin arbiter; the pointer names
// the requester favoured on the next contention.
module rr_arbiter2
  import mram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr_q, ptr_d;

  always_comb begin
    if (req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    else              grant = req;
    ptr_d = advance ? grant[0] : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mram_access_arbiter.sv
// Shares one asynchronous MRAM between two requesters,
// sequencing one timed read or write per grant.
module mram_access_arbiter
  import mram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int T_ACC  = T_ACC_DEF,
  parameter int T_REC  = T_REC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mram_addr,
  output logic [DATA_W-1:0] mram_dq_out,
  output logic              mram_dq_oe,
  input  logic [DATA_W-1:0] mram_dq_in,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);
  localparam int CW = $clog2(T_ACC) + 1;
  localparam int RW = $clog2(T_REC + 1) + 1;
  localparam logic [CW-1:0] ACNT_INIT = CW'(T_ACC - 1);
  localparam logic [RW-1:0] RCNT_INIT =
    RW'((T_REC > 0) ? T_REC - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     acnt_q, acnt_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic              we_q, we_d;
  logic              own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oe_q, oe_d;
  logic              ce_q, ce_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  logic              be_q, be_d;
  logic              busy_q, busy_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        arb_gnt;
  logic              arb_adv;

  assign arb_adv = (state_q == IDLE) && (arb_gnt != 2'b00);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_adv),
    .grant   (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    rcnt_d  = rcnt_q;
    we_d    = we_q;
    own_d   = own_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    rdata_d = rdata_q;
    oe_d    = oe_q;
    ce_d    = ce_q;
    wen_d   = wen_q;
    oen_d   = oen_q;
    be_d    = be_q;
    busy_d  = busy_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (arb_adv) begin
          own_d   = arb_gnt[1];
          we_d    = arb_gnt[1] ? we[1] : we[0];
          addr_d  = arb_gnt[1] ? addr1 : addr0;
          dq_d    = arb_gnt[1] ? wdata1 : wdata0;
          oe_d    = we_d;
          gnt_d   = arb_gnt;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        acnt_d  = ACNT_INIT;
        ce_d    = ~STB_OFF;
        be_d    = ~STB_OFF;
        wen_d   = we_q ? ~STB_OFF : STB_OFF;
        oen_d   = we_q ? STB_OFF : ~STB_OFF;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (acnt_q == '0) begin
          ce_d    = STB_OFF;
          be_d    = STB_OFF;
          wen_d   = STB_OFF;
          oen_d   = STB_OFF;
          if (!we_q) rdata_d = mram_dq_in;
          state_d = HOLD;
        end else begin
          acnt_d = acnt_q - CW'(1);
        end
      end
      HOLD: begin
        done_d = own_q ? 2'b10 : 2'b01;
        oe_d   = 1'b0;
        rcnt_d = RCNT_INIT;
        if (T_REC == 0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (rcnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ce_d    = STB_OFF;
        be_d    = STB_OFF;
        wen_d   = STB_OFF;
        oen_d   = STB_OFF;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acnt_q  <= '0;
      rcnt_q  <= '0;
      we_q    <= 1'b0;
      own_q   <= 1'b0;
      addr_q  <= '0;
      dq_q    <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      ce_q    <= STB_OFF;
      wen_q   <= STB_OFF;
      oen_q   <= STB_OFF;
      be_q    <= STB_OFF;
      busy_q  <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      rcnt_q  <= rcnt_d;
      we_q    <= we_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      ce_q    <= ce_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign mram_addr     = addr_q;
  assign mram_dq_out   = dq_q;
  assign mram_dq_oe    = oe_q;
  assign chip_en       = ce_q;
  assign write_en      = wen_q;
  assign out_en        = oen_q;
  assign lower_byte_en = be_q;
  assign upper_byte_en = be_q;
endmodule
